data_mem_be: RTL and testbench
==============================

# data_mem_be

Parametrised, byte-addressable data memory for the single-cycle/multicycle CPU datapath, replacing the fixed 32-bit word-only data memory. Supports byte, half, word and (when 64-bit) double accesses with per-byte write enables and sign/zero-extended loads. Uses a registered one-cycle read with a valid strobe and a misalignment error flag. Clears itself one word per cycle after reset and holds off requests with a ready flag until the clear completes.

## Interface
- DATA_W, 32, word width in bits; legal values are 32 or 64.
- DEPTH, 128, number of words; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH)+$clog2(DATA_W/8), byte-address width; derived, not overridden.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- req  in  1  access request, sampled only when ready=1
- we  in  1  1 = store, 0 = load
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64)
- unsigned_ld  in  1  1 = zero-extend a load, 0 = sign-extend
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  store data, right-justified (low bits used)
- ready  out  1  block accepts requests
- rvalid  out  1  one-cycle strobe: rdata valid for a completed load
- rdata  out  DATA_W  extended load result
- err  out  1  one-cycle strobe: previous request was misaligned or illegal size

## Operation
- Word index is addr[ADDR_W-1:OFS_W]; byte offset is addr[OFS_W-1:0], with OFS_W=$clog2(DATA_W/8).
- FSM states:
  - CLEAR: reset forces CLEAR, clear_ptr=0, ready=0. Each clock with reset low writes mem[clear_ptr]<=0 and increments clear_ptr. The clock that writes DEPTH-1 moves to IDLE.
  - IDLE: ready=1.
- A request fires when req && ready.
- Alignment:
  - Legal when offset is a multiple of the access bytes (1/2/4/8).
  - size=11 with DATA_W=32 is illegal.
  - An illegal request writes nothing, returns rvalid=0, and raises err=1 on the next cycle. rdata holds its previous value.
- Store:
  - wdata low 8·bytes bits are replicated across lanes.
  - Byte enable covers bytes [offset, offset+bytes-1].
  - Only enabled bytes are updated at the accepting edge.
  - No rvalid for stores.
- Load:
  - The word is read and the lane at offset is extracted.
  - The lane is sign- or zero-extended to DATA_W per unsigned_ld and registered into rdata.
  - rvalid=1 on the next cycle.
- The memory is single-port; one access per cycle.
- Store-then-load to the same word on consecutive cycles returns the new data (the memory write precedes the read).
- req while ready=0 is ignored entirely: no write, no strobe.
- Reset mid-clear restarts clear_ptr at 0.
- Reset on the cycle after a load acceptance forces rvalid=0 and rdata=0.

## Timing
- Reset values: ready=0, rvalid=0, rdata=0, err=0, state=CLEAR, clear_ptr=0.
- ready rises after the DEPTH-th rising edge with reset low. For DEPTH=128, ready is first 1 following edge 128.
- Load latency: 1 cycle. Request at edge N gives rvalid/rdata valid from edge N+1 until edge N+2.
- Store latency: write is visible to a load accepted at edge N+1.
- Back-to-back loads give rvalid high continuously, with new data every cycle.
- err is a 1-cycle pulse aligned to where rvalid would be. rvalid and err are never both high.

## Structure
- Package dmem_pkg holds:
  - size_t enum: SZ_B, SZ_H, SZ_W, SZ_D.
  - state_t enum: CLEAR, IDLE.
  - A function returning access bytes for a size_t.
- Sub-module dmem_lane_fmt (combinational), parametrised on DATA_W:
  - Inputs: size, offset, unsigned_ld, wdata, read word.
  - Outputs: byte-enable vector, replicated write word, extended load value, misalign flag.
- The top holds the memory array, the FSM/clear counter and the output registers.

## Test plan
- Reset clear: assert reset 3 cycles, release, count cycles → ready=0 for exactly 128 cycles then 1. A word load of addr 0x1FC (word 127) → rdata=0x00000000.
- Byte store/load sign: store byte 0x80 at addr 0x005, then load byte signed → rdata=0xFFFFFF80. Load unsigned → 0x00000080. Word load at 0x004 → 0x00008000.
- Half merge: store word 0x11223344 at 0x010, then half 0xBEEF at 0x012 → word load returns 0xBEEF3344. Signed half load at 0x012 → 0xFFFFBEEF.
- Misalign: half load at 0x003 → rvalid=0, err=1 one cycle later. Word store at 0x006 → err=1 and memory unchanged. Size 11 with DATA_W=32 → err=1.
- Back-to-back: store 0xCAFEF00D at 0x020 at edge N, load 0x020 at edge N+1 → rvalid=1 at N+2 with 0xCAFEF00D. Three consecutive loads give rvalid high 3 cycles.
- Reset mid-operation: accept a load, assert reset next edge → rvalid=0, rdata=0, ready=0, and the clear sequence restarts (128 cycles). Repeat with DATA_W=64, DEPTH=16: ready after 16 cycles, and a double load at 0x08 returns the stored 64-bit value.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the byte-enabled data memory
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_t;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    function automatic logic [3:0] size_bytes(size_t s);
        logic [3:0] n;
        case (s)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// rtl/dmem_lane_fmt.sv - byte-enable, store replication, load extraction and alignment check
module dmem_lane_fmt
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFS_W  = $clog2(NB)
) (
    input  size_t             size,
    input  logic [OFS_W-1:0]  offset,
    input  logic              unsigned_ld,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wword,
    output logic [DATA_W-1:0] ldata,
    output logic              misalign
);

    logic [3:0]        nbytes;
    logic [3:0]        ofs_ext;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              fill;

    always_comb begin
        nbytes  = size_bytes(size);
        ofs_ext = 4'(offset);
        // a double access cannot exist in a 32-bit word
        misalign = (|(ofs_ext & (nbytes - 4'd1))) || ((size == SZ_D) && (DATA_W < 64));

        be = '0;
        for (int b = 0; b < NB; b++) begin
            be[b] = !misalign && (4'(b) >= ofs_ext) && (4'(b) < (ofs_ext + nbytes));
        end

        case (size)
            SZ_B:    wword = {NB{wdata[7:0]}};
            SZ_H:    wword = {(NB / 2){wdata[15:0]}};
            SZ_W:    wword = {(NB / 4){wdata[31:0]}};
            default: wword = wdata;
        endcase

        shifted = rword >> {offset, 3'b000};
        keep    = '0;
        for (int i = 0; i < DATA_W; i++) begin
            keep[i] = (i < 8 * int'(nbytes));
        end
        case (size)
            SZ_B:    fill = !unsigned_ld && shifted[7];
            SZ_H:    fill = !unsigned_ld && shifted[15];
            SZ_W:    fill = !unsigned_ld && shifted[31];
            default: fill = !unsigned_ld && shifted[DATA_W-1];
        endcase
        ldata = (shifted & keep) | (~keep & {DATA_W{fill}});
    end

endmodule

// File: rtl/data_mem_be.sv
// rtl/data_mem_be.sv - byte-addressable data memory with registered loads and self-clear
module data_mem_be
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 128,
    localparam int NB     = DATA_W / 8,
    localparam int OFS_W  = $clog2(NB),
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int ADDR_W = IDX_W + OFS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clear_ptr;
    logic [IDX_W-1:0]  idx;
    logic [OFS_W-1:0]  offset;
    logic [DATA_W-1:0] rword;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wword;
    logic [DATA_W-1:0] ldata;
    logic              misalign;
    logic              fire;

    assign idx    = addr[ADDR_W-1:OFS_W];
    assign offset = addr[OFS_W-1:0];
    assign rword  = mem[idx];
    assign ready  = (state_q == IDLE);
    assign fire   = req && ready;

    dmem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
        .size        (size_t'(size)),
        .offset      (offset),
        .unsigned_ld (unsigned_ld),
        .wdata       (wdata),
        .rword       (rword),
        .be          (be),
        .wword       (wword),
        .ldata       (ldata),
        .misalign    (misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (clear_ptr == IDX_W'(DEPTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_ptr <= '0;
        end else if (state_q == CLEAR) begin
            clear_ptr <= clear_ptr + 1'b1;
        end
    end

    // be is already all-zero for a misaligned request, so it cannot write
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem[clear_ptr] <= '0;
            end else if (fire && we) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= fire && !we && !misalign;
            err    <= fire && misalign;
            if (fire && !we && !misalign) rdata <= ldata;
        end
    end

endmodule

// File: tb/tb_data_mem_be.sv
// tb/tb_data_mem_be.sv - randomized scoreboard bench for data_mem_be (32/128 and 64/16)
module tb_data_mem_be;

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, req, we, uns_ld, sel;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [63:0] wdata;

    logic        a_ready, a_rvalid, a_err;
    logic [31:0] a_rdata;
    logic        b_ready, b_rvalid, b_err;
    logic [63:0] b_rdata;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    logic [7:0]  mm [2][512];
    logic [63:0] last [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_be #(.DATA_W(32), .DEPTH(128)) u_a (
        .clk(clk), .reset(reset), .req(req && !sel), .we(we), .size(size),
        .unsigned_ld(uns_ld), .addr(addr), .wdata(wdata[31:0]),
        .ready(a_ready), .rvalid(a_rvalid), .rdata(a_rdata), .err(a_err)
    );

    data_mem_be #(.DATA_W(64), .DEPTH(16)) u_b (
        .clk(clk), .reset(reset), .req(req && sel), .we(we), .size(size),
        .unsigned_ld(uns_ld), .addr(addr[6:0]), .wdata(wdata),
        .ready(b_ready), .rvalid(b_rvalid), .rdata(b_rdata), .err(b_err)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, want);
        end
    endfunction

    function automatic bit legal(bit s, int sz, int a);
        int nb = 1 << sz;
        return !(sz == 3 && !s) && (a % nb == 0);
    endfunction

    function automatic logic [63:0] model_load(bit s, int sz, bit uns, int a);
        int nb = 1 << sz;
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[s][a + i];
        if (!uns && v[8*nb-1]) for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
        if (!s) v[63:32] = '0;
        return v;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 512; i++) mm[s][i] = 8'h00;
            last[s] = '0;
        end
        qa.delete();
        qb.delete();
    endfunction

    function automatic void qpush(bit s, exp_t e);
        if (s) qb.push_back(e); else qa.push_back(e);
    endfunction

    function automatic int qsize(bit s);
        return s ? qb.size() : qa.size();
    endfunction

    function automatic exp_t qpop(bit s);
        return s ? qb.pop_front() : qa.pop_front();
    endfunction

    // one request per cycle; when use_want is set the test-plan constant is the expectation
    task automatic op(bit s, bit w, int sz, bit uns, int a, logic [63:0] wd,
                      bit use_want = 1'b0, logic [63:0] want = '0);
        exp_t e;
        bit   fires;
        sel = s; req = 1'b1; we = w; size = 2'(sz); uns_ld = uns; addr = 9'(a); wdata = wd;
        fires = s ? b_ready : a_ready;
        if (fires) begin
            e.cyc = cyc + 1;
            if (!legal(s, sz, a)) begin
                e.is_err = 1'b1;
                e.data   = last[s];
                qpush(s, e);
            end else if (w) begin
                for (int i = 0; i < (1 << sz); i++) mm[s][a + i] = wd[8*i +: 8];
            end else begin
                e.is_err = 1'b0;
                e.data   = use_want ? want : model_load(s, sz, uns, a);
                last[s]  = e.data;
                qpush(s, e);
            end
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic mon(bit s);
        logic        rv, er;
        logic [63:0] rd;
        exp_t        e;
        string       p;
        p  = s ? "b" : "a";
        rv = s ? b_rvalid : a_rvalid;
        er = s ? b_err : a_err;
        rd = s ? b_rdata : {32'b0, a_rdata};
        while (qsize(s) > 0 && (s ? qb[0].cyc : qa[0].cyc) < cyc) begin
            e = qpop(s);
            chk({p, "_missed_strobe_cycle"}, 64'(cyc), 64'(e.cyc));
        end
        if (rv === 1'b1 && er === 1'b1) begin
            chk({p, "_rvalid_and_err"}, 64'(rv && er), 64'd0);
        end else if (rv === 1'b1 || er === 1'b1) begin
            if (qsize(s) == 0) begin
                chk({p, "_unexpected_strobe"}, {62'd0, rv, er}, 64'd0);
            end else begin
                e = qpop(s);
                chk({p, "_strobe_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({p, "_err_flag"}, 64'(er), 64'(e.is_err));
                chk({p, "_rdata"}, rd, e.data);
            end
        end
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        req   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    // ready must stay low for exactly DEPTH edges; a store issued meanwhile is ignored
    task automatic count_clear();
        int na = 0;
        int nb = 0;
        for (int n = 1; n <= 300 && na == 0; n++) begin
            if (n == 4) begin
                sel = 1'b0; we = 1'b1; size = 2'd2; uns_ld = 1'b0;
                addr = 9'h1FC; wdata = 64'hDEADBEEF; req = 1'b1;
            end else begin
                req = 1'b0;
            end
            @(posedge clk);
            #1;
            if (a_ready && na == 0) na = n;
            if (b_ready && nb == 0) nb = n;
        end
        req = 1'b0;
        chk("clear_len_a", 64'(na), 64'd128);
        chk("clear_len_b", 64'(nb), 64'd16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; uns_ld = 1'b0; sel = 1'b0;
        size = 2'd0; addr = '0; wdata = '0;
        model_clear();
        fork
            forever begin
                @(negedge clk);
                mon(1'b0);
                mon(1'b1);
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready_a", 64'(a_ready), 64'd0);
        chk("reset_rvalid_a", 64'(a_rvalid), 64'd0);
        chk("reset_rdata_a", 64'(a_rdata), 64'd0);
        chk("reset_err_a", 64'(a_err), 64'd0);
        chk("reset_ready_b", 64'(b_ready), 64'd0);
        chk("reset_rdata_b", b_rdata, 64'd0);
        reset = 1'b0;
        count_clear();

        op(0, 0, 2, 0, 'h1FC, 0, 1, 64'h0);
        op(0, 1, 0, 0, 'h005, 64'h80);
        op(0, 0, 0, 0, 'h005, 0, 1, 64'hFFFFFF80);
        op(0, 0, 0, 1, 'h005, 0, 1, 64'h00000080);
        op(0, 0, 2, 0, 'h004, 0, 1, 64'h00008000);
        op(0, 1, 2, 0, 'h010, 64'h11223344);
        op(0, 1, 1, 0, 'h012, 64'hBEEF);
        op(0, 0, 2, 0, 'h010, 0, 1, 64'hBEEF3344);
        op(0, 0, 1, 0, 'h012, 0, 1, 64'hFFFFBEEF);
        op(0, 0, 1, 0, 'h003, 0);
        op(0, 1, 2, 0, 'h006, 64'h12345678);
        op(0, 0, 2, 0, 'h004, 0, 1, 64'h00008000);
        op(0, 0, 3, 0, 'h000, 0);
        op(0, 1, 2, 0, 'h020, 64'hCAFEF00D);
        op(0, 0, 2, 0, 'h020, 0, 1, 64'hCAFEF00D);
        op(0, 0, 2, 0, 'h010, 0, 1, 64'hBEEF3344);
        op(0, 0, 0, 1, 'h013, 0, 1, 64'h000000BE);

        op(1, 1, 3, 0, 'h08, 64'h0123456789ABCDEF);
        op(1, 0, 3, 0, 'h08, 0, 1, 64'h0123456789ABCDEF);
        op(1, 0, 2, 0, 'h0C, 0, 1, 64'h0000000001234567);
        op(1, 0, 2, 0, 'h08, 0, 1, 64'hFFFFFFFF89ABCDEF);
        op(1, 0, 3, 0, 'h04, 0);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 300; i++) begin
                int sz = $urandom_range(0, 3);
                int a  = k ? $urandom_range(0, 127) : $urandom_range(0, 63);
                if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
                if ($urandom_range(0, 5) == 0) begin
                    @(posedge clk);
                    #1;
                end
                op(k[0], 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                   {$urandom, $urandom});
            end
        end

        op(0, 1, 2, 0, 'h020, 64'hCAFEF00D);
        op(0, 0, 2, 0, 'h020, 0, 1, 64'hCAFEF00D);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midop_rvalid", 64'(a_rvalid), 64'd0);
        chk("midop_rdata", 64'(a_rdata), 64'd0);
        chk("midop_ready", 64'(a_ready), 64'd0);
        reset = 1'b0;
        model_clear();
        count_clear();
        op(0, 0, 2, 0, 'h020, 0, 1, 64'h0);
        op(1, 0, 3, 0, 'h08, 0, 1, 64'h0);

        do_reset(2);
        repeat (50) @(posedge clk);
        #1;
        do_reset(1);
        count_clear();
        op(0, 0, 2, 0, 'h1FC, 0, 1, 64'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_a", 64'(qa.size()), 64'd0);
        chk("pending_b", 64'(qb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
